// File: rtl/omp_pingpong_regbank_pkg.sv
// Shared defaults and shadow-bank FSM encoding for the OMP ping-pong register bank.
// Word width, depth and index-width helper live here so both bank copies agree.
package omp_pingpong_regbank_pkg;

    localparam int DATA_W_DEF = 81;
    localparam int DEPTH_DEF  = 15;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/omp_regbank_core.sv
// One storage bank: whole-bank parallel load, single-word write,
// flat combinational read and one indexed combinational read.
module omp_regbank_core
    import omp_pingpong_regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_en,
    input  logic [DATA_W*DEPTH-1:0]   load_data,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [DATA_W-1:0]         rd_data,
    output logic [DATA_W*DEPTH-1:0]   q
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= load_data[i*DATA_W +: DATA_W];
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign q[g*DATA_W +: DATA_W] = mem[g];
    end

    assign rd_data = ({1'b0, rd_addr} < DEPTH_C) ? mem[rd_addr] : '0;

endmodule

// File: rtl/omp_pingpong_regbank.sv
// Double-buffered register bank: shadow fills while active feeds Q; swap promotes.
// Define OMP_REGBANK_TRISTATE_EN to float Q when rd_en is low (shared-bus mode).
module omp_pingpong_regbank
    import omp_pingpong_regbank_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      load_en,
    input  logic [DATA_W*DEPTH-1:0]   PD,
    input  logic                      swap_req,
    output logic                      swap_ack,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_err,
    input  logic                      rd_en,
    output logic [DATA_W*DEPTH-1:0]   Q,
    input  logic [ADDR_W-1:0]         rd_idx,
    output logic [DATA_W-1:0]         rd_word,
    output logic                      shadow_full,
    output logic [ADDR_W:0]           fill_cnt
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    logic [0:0] state;
    logic       active_sel;
    logic       swap_go;
    logic       load_go;
    logic       stream_go;
    logic       wr_ok;

    logic [DATA_W*DEPTH-1:0] bank_q     [2];
    logic [DATA_W-1:0]       bank_rword [2];
    logic [DATA_W*DEPTH-1:0] act_q;
    logic [DATA_W-1:0]       act_rword;

    // Arbitration: swap beats load beats stream; a swap edge also blocks word writes
    assign in_ready  = (state == ST_FILL);
    assign swap_go   = swap_req && (state == ST_FULL);
    assign load_go   = load_en && !swap_go;
    assign stream_go = in_valid && in_ready && !swap_go && !load_en;
    assign wr_ok     = wr_en && ({1'b0, wr_addr} < DEPTH_C) && !swap_go;

    assign shadow_full = (state == ST_FULL);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BSEL = (b == 1);

        logic              is_act;
        logic              bk_load;
        logic              bk_we;
        logic [ADDR_W-1:0] bk_addr;
        logic [DATA_W-1:0] bk_data;

        assign is_act  = (active_sel == BSEL);
        assign bk_load = load_go && !is_act;
        assign bk_we   = is_act ? wr_ok : stream_go;
        assign bk_addr = is_act ? wr_addr : fill_cnt[ADDR_W-1:0];
        assign bk_data = is_act ? wr_data : in_data;

        omp_regbank_core #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_core (
            .clk       (clk),
            .rst_n     (rst_n),
            .load_en   (bk_load),
            .load_data (PD),
            .wr_en     (bk_we),
            .wr_addr   (bk_addr),
            .wr_data   (bk_data),
            .rd_addr   (rd_idx),
            .rd_data   (bank_rword[b]),
            .q         (bank_q[b])
        );
    end

    assign act_q     = active_sel ? bank_q[1] : bank_q[0];
    assign act_rword = active_sel ? bank_rword[1] : bank_rword[0];

`ifdef OMP_REGBANK_TRISTATE_EN
    assign Q = rd_en ? act_q : 'z;
`else
    assign Q = rd_en ? act_q : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FILL;
            active_sel <= 1'b0;
            fill_cnt   <= '0;
            swap_ack   <= 1'b0;
            wr_err     <= 1'b0;
            rd_word    <= '0;
        end else begin
            swap_ack <= swap_go;
            wr_err   <= wr_en && !wr_ok;
            rd_word  <= act_rword;
            if (swap_go) begin
                active_sel <= ~active_sel;
                fill_cnt   <= '0;
                state      <= ST_FILL;
            end else if (load_go) begin
                fill_cnt <= DEPTH_C;
                state    <= ST_FULL;
            end else if (stream_go) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == LAST_C) begin
                    state <= ST_FULL;
                end
            end
        end
    end

endmodule

// File: tb/tb_omp_pingpong_regbank.sv
// Directed bench for omp_pingpong_regbank: shadow model plus a queue of
// expected active-bank words that is drained against Q after every swap.
module tb_omp_pingpong_regbank;

    localparam int DW = 81;
    localparam int DP = 15;
    localparam int AW = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              load_en;
    logic [DW*DP-1:0]  PD;
    logic              swap_req;
    logic              swap_ack;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_err;
    logic              rd_en;
    logic [DW*DP-1:0]  Q;
    logic [AW-1:0]     rd_idx;
    logic [DW-1:0]     rd_word;
    logic              shadow_full;
    logic [AW:0]       fill_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sh_m  [DP];
    logic [DW-1:0] act_m [DP];
    logic [DW-1:0] sb    [$];
    logic [DW-1:0] q_off;

    omp_pingpong_regbank #(
        .DATA_W (DW),
        .DEPTH  (DP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .load_en     (load_en),
        .PD          (PD),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .rd_en       (rd_en),
        .Q           (Q),
        .rd_idx      (rd_idx),
        .rd_word     (rd_word),
        .shadow_full (shadow_full),
        .fill_cnt    (fill_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] qword(input int i);
        return Q[i*DW +: DW];
    endfunction

    task automatic promote();
        for (int i = 0; i < DP; i++) begin
            sb.push_back(sh_m[i]);
            act_m[i] = sh_m[i];
        end
    endtask

    task automatic check_q(input string tag);
        logic [DW-1:0] exp;
        for (int i = 0; i < DP; i++) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, qword(i), {DW{1'bx}});
            end else begin
                exp = sb.pop_front();
                chk(tag, qword(i), exp);
            end
        end
    endtask

    task automatic set_pd(input int base);
        for (int i = 0; i < DP; i++) begin
            PD[i*DW +: DW] = DW'(base + i);
            sh_m[i] = DW'(base + i);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        load_en  = 1'b0;
        PD       = '0;
        swap_req = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = 1'b1;
        rd_idx   = '0;
`ifdef OMP_REGBANK_TRISTATE_EN
        q_off = 'z;
`else
        q_off = '0;
`endif
        for (int i = 0; i < DP; i++) begin
            sh_m[i]  = '0;
            act_m[i] = '0;
        end

        #3;
        chk("rst_fill_cnt", DW'(fill_cnt), '0);
        chk("rst_full", DW'(shadow_full), '0);
        chk("rst_in_ready", DW'(in_ready), 1);
        chk("rst_swap_ack", DW'(swap_ack), '0);
        chk("rst_wr_err", DW'(wr_err), '0);
        chk("rst_rd_word", rd_word, '0);
        chk("rst_q", qword(0), '0);
        tick();
        rst_n = 1'b1;

        // stream 1..15 into the shadow
        in_valid = 1'b1;
        for (int i = 1; i <= DP; i++) begin
            in_data = DW'(i);
            sh_m[i-1] = DW'(i);
            tick();
        end
        chk("stream_cnt", DW'(fill_cnt), DW'(DP));
        chk("stream_full", DW'(shadow_full), 1);
        chk("stream_ready", DW'(in_ready), '0);
        in_data = DW'(99);
        tick();
        in_valid = 1'b0;
        chk("full_beat_ignored", DW'(fill_cnt), DW'(DP));
        chk("active_untouched", qword(0), '0);

        swap_req = 1'b1;
        tick();
        chk("swap1_ack", DW'(swap_ack), 1);
        promote();
        swap_req = 1'b0;
        tick();
        chk("swap1_ack_pulse", DW'(swap_ack), '0);
        chk("swap1_cnt", DW'(fill_cnt), '0);
        chk("swap1_ready", DW'(in_ready), 1);
        check_q("swap1_q");

        // swap request while still filling
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = DW'('h200 + i);
            tick();
        end
        in_valid = 1'b0;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("fill_swap_noack", DW'(swap_ack), '0);
        chk("fill_swap_cnt", DW'(fill_cnt), DW'(7));
        chk("fill_swap_q", qword(0), act_m[0]);
        tick();
        chk("fill_swap_noack2", DW'(swap_ack), '0);

        // parallel load beats a same-cycle stream beat
        set_pd('h100);
        load_en  = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'('h777);
        tick();
        load_en  = 1'b0;
        in_valid = 1'b0;
        chk("load_cnt", DW'(fill_cnt), DW'(DP));
        chk("load_full", DW'(shadow_full), 1);
        swap_req = 1'b1;
        tick();
        chk("swap2_ack", DW'(swap_ack), 1);
        promote();
        swap_req = 1'b0;
        tick();
        check_q("load_q");

        // in-place writes to the active bank
        wr_en   = 1'b1;
        wr_addr = AW'(3);
        wr_data = DW'('hABC);
        tick();
        act_m[3] = DW'('hABC);
        chk("wr_ok_err", DW'(wr_err), '0);
        chk("wr_q3", qword(3), act_m[3]);
        wr_addr = AW'(15);
        wr_data = DW'('hDEF);
        rd_idx  = AW'(3);
        tick();
        wr_en = 1'b0;
        chk("wr_oob_err", DW'(wr_err), 1);
        chk("wr_oob_q3", qword(3), act_m[3]);
        chk("wr_oob_q14", qword(14), act_m[14]);
        chk("rd_word3", rd_word, act_m[3]);
        rd_idx = AW'(15);
        tick();
        chk("wr_err_pulse", DW'(wr_err), '0);
        chk("rd_word_oob", rd_word, '0);
        rd_idx = '0;

        rd_en = 1'b0;
        #1;
        chk("rd_en_off", qword(3), q_off);
        rd_en = 1'b1;

        // in-place write colliding with a swap is dropped
        set_pd('h300);
        load_en = 1'b1;
        tick();
        load_en  = 1'b0;
        swap_req = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = '0;
        wr_data  = DW'(5);
        tick();
        swap_req = 1'b0;
        wr_en    = 1'b0;
        chk("wrswap_ack", DW'(swap_ack), 1);
        chk("wrswap_err", DW'(wr_err), 1);
        promote();
        tick();
        check_q("wrswap_q");

        // asynchronous reset in the middle of a fill
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = DW'('h500 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("midfill_cnt", DW'(fill_cnt), DW'(9));
        rst_n = 1'b0;
        #1;
        chk("midfill_rst_cnt", DW'(fill_cnt), '0);
        chk("midfill_rst_ready", DW'(in_ready), 1);
        chk("midfill_rst_full", DW'(shadow_full), '0);
        chk("midfill_rst_q", qword(0), '0);
        chk("midfill_rst_rd", rd_word, '0);
        rst_n = 1'b1;
        tick();

        // asynchronous reset during the swap-ack cycle
        set_pd('h400);
        load_en = 1'b1;
        tick();
        load_en  = 1'b0;
        swap_req = 1'b1;
        tick();
        chk("swap3_ack", DW'(swap_ack), 1);
        chk("swap3_q5", qword(5), DW'('h405));
        rst_n = 1'b0;
        #1;
        swap_req = 1'b0;
        chk("midswap_rst_ack", DW'(swap_ack), '0);
        chk("midswap_rst_q", qword(5), '0);
        chk("midswap_rst_cnt", DW'(fill_cnt), '0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_full", DW'(shadow_full), '0);
        chk("post_rst_ack", DW'(swap_ack), '0);
        chk("post_rst_q", qword(5), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
